// File: rtl/div_pkg.sv
// +--------------------------------------------------------------------------+
// | div_pkg : shared types and helpers for the arbitrated divider            |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

package div_pkg;

    localparam int DIV_WIDTH = 26;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Index width for n requestors; a single requestor still gets one bit.
    function automatic int ch_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick, searching up from ptr       |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
    import div_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int CH_W     = ch_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [CH_W-1:0]     ptr,
    output logic [CHANNELS-1:0] winner,
    output logic [CH_W-1:0]     winner_idx,
    output logic                any
);

    logic [CH_W:0]   w_sum;
    logic [CH_W-1:0] w_cand;

    always_comb begin
        winner_idx = '0;
        any        = 1'b0;
        w_sum      = '0;
        w_cand     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_sum = {1'b0, ptr} + (CH_W+1)'(i);
            if (w_sum >= (CH_W+1)'(CHANNELS)) begin
                w_sum = w_sum - (CH_W+1)'(CHANNELS);
            end
            w_cand = w_sum[CH_W-1:0];
            if (!any && req[w_cand]) begin
                any        = 1'b1;
                winner_idx = w_cand;
            end
        end
    end

    assign winner = any ? (CHANNELS'(1) << winner_idx) : '0;

endmodule

`default_nettype wire

// File: rtl/multi_channel_divider.sv
// +--------------------------------------------------------------------------+
// | multi_channel_divider : round-robin shared restoring unsigned divider    |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module multi_channel_divider
    import div_pkg::*;
#(
    parameter int WIDTH    = DIV_WIDTH,
    parameter int CHANNELS = 2,
    parameter int CH_W     = ch_width(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      en,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS*WIDTH-1:0] dividend,
    input  logic [CHANNELS*WIDTH-1:0] divisor,
    output logic [CHANNELS-1:0]       grant,
    output logic [CHANNELS-1:0]       valid,
    output logic [WIDTH-1:0]          res,
    output logic [WIDTH-1:0]          rem,
    output logic                      div_by_zero,
    output logic                      busy,
    output logic [CH_W-1:0]           active_ch
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t          r_state;
    div_state_t          w_next;
    logic                w_accept;

    logic [CH_W-1:0]     r_ptr;
    logic [CHANNELS-1:0] w_win_onehot;
    logic [CH_W-1:0]     w_win_idx;
    logic                w_win_any;
    logic [WIDTH-1:0]    w_win_dvd;
    logic [WIDTH-1:0]    w_win_dvs;
    logic                w_win_zero;

    logic [WIDTH-1:0]    r_part;
    logic [WIDTH-1:0]    r_quo;
    logic [WIDTH-1:0]    r_dvs;
    logic                r_zero;
    logic [CNT_W-1:0]    r_cnt;

    logic [WIDTH:0]      w_shift;
    logic [WIDTH-1:0]    w_diff;
    logic                w_ge;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W)
    ) u_arb (
        .req        (req),
        .ptr        (r_ptr),
        .winner     (w_win_onehot),
        .winner_idx (w_win_idx),
        .any        (w_win_any)
    );

    assign w_win_dvd  = dividend[int'(w_win_idx)*WIDTH +: WIDTH];
    assign w_win_dvs  = divisor[int'(w_win_idx)*WIDTH +: WIDTH];
    assign w_win_zero = (w_win_dvs == '0);

    // The stored remainder is always below the divisor, so only the shifted
    // value needs the extra bit for the compare.
    assign w_shift = {r_part, r_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs});
    assign w_diff  = w_shift[WIDTH-1:0] - r_dvs;

    assign busy = (r_state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (en && w_win_any) begin
                    w_accept = 1'b1;
                    w_next   = w_win_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (en && (r_cnt == CNT_W'(1))) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (en) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr       <= '0;
            grant       <= '0;
            valid       <= '0;
            res         <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
            active_ch   <= '0;
            r_part      <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_zero      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            // Pulses clear on every edge, even with en low.
            grant <= '0;
            valid <= '0;
            if (w_accept) begin
                grant     <= w_win_onehot;
                active_ch <= w_win_idx;
                r_ptr     <= (w_win_idx == CH_W'(CHANNELS-1)) ? '0 : w_win_idx + 1'b1;
                r_part    <= '0;
                r_quo     <= w_win_dvd;
                r_dvs     <= w_win_dvs;
                r_zero    <= w_win_zero;
                r_cnt     <= CNT_W'(WIDTH);
            end
            if (en && (r_state == CALC)) begin
                r_part <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                r_quo  <= {r_quo[WIDTH-2:0], w_ge};
                r_cnt  <= r_cnt - 1'b1;
            end
            if (en && (r_state == DONE)) begin
                valid       <= CHANNELS'(1) << active_ch;
                div_by_zero <= r_zero;
                if (r_zero) begin
                    res <= '1;
                    rem <= r_quo;
                end else begin
                    res <= r_quo;
                    rem <= r_part;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multi_channel_divider.sv
// +--------------------------------------------------------------------------+
// | tb_multi_channel_divider : directed vector bench, 2-ch/26b and 4-ch/8b   |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_multi_channel_divider;

    localparam int AW = 26;
    localparam int AC = 2;
    localparam int BW = 8;
    localparam int BC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic               a_en;
    logic [AC-1:0]      a_req;
    logic [AC*AW-1:0]   a_dividend, a_divisor;
    logic [AC-1:0]      a_grant, a_valid;
    logic [AW-1:0]      a_res, a_rem;
    logic               a_dbz, a_busy;
    logic [0:0]         a_active_ch;

    logic               b_en;
    logic [BC-1:0]      b_req;
    logic [BC*BW-1:0]   b_dividend, b_divisor;
    logic [BC-1:0]      b_grant, b_valid;
    logic [BW-1:0]      b_res, b_rem;
    logic               b_dbz, b_busy;
    logic [1:0]         b_active_ch;

    multi_channel_divider #(.WIDTH(AW), .CHANNELS(AC)) u_dut_a (
        .clock(clk), .reset(rst), .en(a_en), .req(a_req),
        .dividend(a_dividend), .divisor(a_divisor),
        .grant(a_grant), .valid(a_valid), .res(a_res), .rem(a_rem),
        .div_by_zero(a_dbz), .busy(a_busy), .active_ch(a_active_ch)
    );

    multi_channel_divider #(.WIDTH(BW), .CHANNELS(BC)) u_dut_b (
        .clock(clk), .reset(rst), .en(b_en), .req(b_req),
        .dividend(b_dividend), .divisor(b_divisor),
        .grant(b_grant), .valid(b_valid), .res(b_res), .rem(b_rem),
        .div_by_zero(b_dbz), .busy(b_busy), .active_ch(b_active_ch)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int            ch;
        logic [AW-1:0] dvd, dvs, q, r;
        logic          z;
    } vec_t;

    typedef struct {
        logic [BC-1:0]   mask;
        int              n;
        logic [2:0][1:0] ord;
    } burst_t;

    vec_t   vecs[10];
    burst_t bursts[3];
    logic [BW-1:0] b_q[BC];
    logic [BW-1:0] b_r[BC];
    logic          b_z[BC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Issue one request on DUT A and follow it through to its result.
    task automatic run_op(input vec_t v, input int stall_at, input string tag);
        int n;
        logic [AC-1:0] exp_oh;
        exp_oh = AC'(1) << v.ch;
        a_dividend[v.ch*AW +: AW] = v.dvd;
        a_divisor[v.ch*AW +: AW]  = v.dvs;
        a_req[v.ch] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (a_grant !== exp_oh && n < 100);
        chk({tag, "_grant"}, a_grant, exp_oh);
        chk({tag, "_active_ch"}, a_active_ch, v.ch);
        chk({tag, "_busy"}, a_busy, 1);
        a_req[v.ch] = 1'b0;
        n = 0;
        do begin
            @(negedge clk); n++;
            if (stall_at > 0 && n == stall_at) a_en = 1'b0;
            if (stall_at > 0 && n == stall_at + 5) a_en = 1'b1;
        end while (a_valid === '0 && n < 100);
        a_en = 1'b1;
        chk({tag, "_latency"}, n, (v.z ? 1 : AW + 1) + (stall_at > 0 ? 5 : 0));
        chk({tag, "_valid"}, a_valid, exp_oh);
        chk({tag, "_res"}, a_res, v.q);
        chk({tag, "_rem"}, a_rem, v.r);
        chk({tag, "_dbz"}, a_dbz, v.z);
        chk({tag, "_busy_end"}, a_busy, 0);
    endtask

    initial begin
        int n;
        int seen;
        int ch;
        logic [AW-1:0] alt_q[2];
        logic [AW-1:0] alt_r[2];

        vecs[0] = '{0, 26'd100,      26'd7,        26'd14,       26'd2,   1'b0};
        vecs[1] = '{1, 26'd555,      26'd0,        26'h3FFFFFF,  26'd555, 1'b1};
        vecs[2] = '{0, 26'h3FFFFFF,  26'd1,        26'h3FFFFFF,  26'd0,   1'b0};
        vecs[3] = '{1, 26'h3FFFFFF,  26'h3FFFFFF,  26'd1,        26'd0,   1'b0};
        vecs[4] = '{0, 26'd5,        26'd9,        26'd0,        26'd5,   1'b0};
        vecs[5] = '{1, 26'd0,        26'd3,        26'd0,        26'd0,   1'b0};
        vecs[6] = '{0, 26'd1000,     26'd10,       26'd100,      26'd0,   1'b0};
        vecs[7] = '{1, 26'h2000000,  26'd3,        26'hAAAAAA,   26'd2,   1'b0};
        vecs[8] = '{0, 26'd123456,   26'd789,      26'd156,      26'd372, 1'b0};
        vecs[9] = '{0, 26'd0,        26'd0,        26'h3FFFFFF,  26'd0,   1'b1};

        bursts[0] = '{4'b1011, 3, {2'd3, 2'd1, 2'd0}};
        bursts[1] = '{4'b0100, 1, {2'd0, 2'd0, 2'd2}};
        bursts[2] = '{4'b1011, 3, {2'd1, 2'd0, 2'd3}};
        b_q = '{8'd28, 8'd15, 8'hFF, 8'd1};
        b_r = '{8'd4,  8'd15, 8'd9,  8'd0};
        b_z = '{1'b0,  1'b0,  1'b1,  1'b0};

        alt_q = '{26'd6, 26'd5};
        alt_r = '{26'd2, 26'd1};

        rst = 1'b1;
        a_en = 1'b1; a_req = '0; a_dividend = '0; a_divisor = '0;
        b_en = 1'b1; b_req = '0;
        b_dividend = {8'd100, 8'd9, 8'd255, 8'd200};
        b_divisor  = {8'd100, 8'd0, 8'd16,  8'd7};
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_grant", a_grant, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_res", a_res, 0);
        chk("rst_rem", a_rem, 0);
        chk("rst_dbz", a_dbz, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_active_ch", a_active_ch, 0);
        chk("rst_b_busy", b_busy, 0);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], 0, $sformatf("v%0d", i));
        end

        // Both channels hold req high: grants must alternate from pointer 0.
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        a_dividend = {26'd21, 26'd20};
        a_divisor  = {26'd4,  26'd3};
        a_req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (a_grant === '0 && n < 100);
            chk($sformatf("alt%0d_grant", k), a_grant, AC'(1) << (k % 2));
            if (k == 3) a_req = '0;
            n = 0;
            do begin @(negedge clk); n++; end while (a_valid === '0 && n < 100);
            chk($sformatf("alt%0d_valid", k), a_valid, AC'(1) << (k % 2));
            chk($sformatf("alt%0d_res", k), a_res, alt_q[k % 2]);
            chk($sformatf("alt%0d_rem", k), a_rem, alt_r[k % 2]);
        end

        // Reset in the middle of a calculation: no result may escape.
        a_dividend[0 +: AW] = 26'd1000;
        a_divisor[0 +: AW]  = 26'd10;
        a_req[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (a_grant === '0 && n < 100);
        chk("abort_grant", a_grant, 2'b01);
        a_req[0] = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (a_valid !== '0) seen++;
        end
        chk("abort_no_valid", seen, 0);
        chk("abort_res", a_res, 0);
        chk("abort_rem", a_rem, 0);
        chk("abort_busy", a_busy, 0);
        chk("abort_active_ch", a_active_ch, 0);
        run_op('{0, 26'd1000, 26'd10, 26'd100, 26'd0, 1'b0}, 0, "after_abort");

        // Enable low mid-CALC stretches latency by exactly the stall.
        run_op('{1, 26'd65535, 26'd255, 26'd257, 26'd0, 1'b0}, 10, "stall");

        // Enable low in IDLE: a pending request must not be granted.
        a_en = 1'b0;
        a_req[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("en_low_grant%0d", c), a_grant, 0);
        end
        chk("en_low_busy", a_busy, 0);
        a_en = 1'b1;
        run_op('{1, 26'd5, 26'd2, 26'd2, 26'd1, 1'b0}, 0, "en_resume");

        // Four-channel round-robin, including wrap from the top index.
        for (int bi = 0; bi < 3; bi++) begin
            b_req = bursts[bi].mask;
            for (int k = 0; k < bursts[bi].n; k++) begin
                ch = int'(bursts[bi].ord[k]);
                n = 0;
                do begin @(negedge clk); n++; end while (b_grant === '0 && n < 100);
                chk($sformatf("b%0d_%0d_grant", bi, k), b_grant, BC'(1) << ch);
                b_req[ch] = 1'b0;
                n = 0;
                do begin @(negedge clk); n++; end while (b_valid === '0 && n < 100);
                chk($sformatf("b%0d_%0d_latency", bi, k), n, b_z[ch] ? 1 : BW + 1);
                chk($sformatf("b%0d_%0d_valid", bi, k), b_valid, BC'(1) << ch);
                chk($sformatf("b%0d_%0d_res", bi, k), b_res, b_q[ch]);
                chk($sformatf("b%0d_%0d_rem", bi, k), b_rem, b_r[ch]);
                chk($sformatf("b%0d_%0d_dbz", bi, k), b_dbz, b_z[ch]);
            end
            b_req = '0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
